// File: rtl/nibble_route_scheduler.sv
// Round-robin scheduler sharing one 4-bit nibble mux/demux path between four
// requesters. Each grant runs SETUP -> ACTIVE (SLOT_CYCLES cycles of en) -> RELEASE.
// The demux select is looked up in a writable 4-entry route table at grant time.
// Ports:
//   i_clk, i_rst          : clock (rising edge), synchronous active-high reset
//   i_req[3:0]            : per-source request, bit i owns sw[4i+3:4i]
//   i_route_we/src/dst    : route-table write strobe, entry index, destination nibble
//   o_mux_sel, o_demux_sel: source mux / destination demux selects
//   o_en                  : demux enable, o_grant: one-hot grant, o_busy: not idle
module nibble_route_scheduler #(
  parameter int SLOT_CYCLES = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_req,
  input  logic       i_route_we,
  input  logic [1:0] i_route_src,
  input  logic [1:0] i_route_dst,
  output logic [1:0] o_mux_sel,
  output logic [1:0] o_demux_sel,
  output logic       o_en,
  output logic [3:0] o_grant,
  output logic       o_busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETUP   = 2'd1,
    S_ACTIVE  = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       w_grant_now;
  logic [1:0] r_last;
  logic [3:0] r_cnt;
  logic [1:0] r_route [4];
  logic [1:0] r_mux_sel;
  logic [1:0] r_demux_sel;
  logic [3:0] r_grant;
  logic       r_en;
  logic       r_busy;

  logic       w_found;
  logic [1:0] w_pick;
  logic [1:0] w_cand;

  // Rotating-priority search: start one past the last winner and wrap, so the
  // previous owner is considered last and cannot starve anyone else.
  always_comb begin
    w_found = 1'b0;
    w_pick  = 2'd0;
    w_cand  = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      w_cand = r_last + 2'(i);
      if (!w_found && i_req[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_now = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_SETUP;
          w_grant_now = 1'b1;
        end
      end
      S_SETUP: begin
        w_state_nxt = S_ACTIVE;
      end
      S_ACTIVE: begin
        // r_mux_sel holds the granted index for the whole slot.
        if (r_cnt == 4'd0 || !i_req[r_mux_sel]) begin
          w_state_nxt = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (w_found) begin
          w_state_nxt = S_SETUP;
          w_grant_now = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_last      <= 2'd3;
      r_cnt       <= 4'd0;
      r_mux_sel   <= 2'd0;
      r_demux_sel <= 2'd0;
      r_grant     <= 4'd0;
      r_en        <= 1'b0;
      r_busy      <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_route[i] <= 2'(i);
      end
    end else begin
      r_state <= w_state_nxt;
      // Table write and grant lookup on the same edge: the lookup below reads
      // the pre-edge value, so the grant gets the old route.
      if (i_route_we) begin
        r_route[i_route_src] <= i_route_dst;
      end
      if (w_grant_now) begin
        r_last      <= w_pick;
        r_cnt       <= 4'(SLOT_CYCLES - 1);
        r_mux_sel   <= w_pick;
        r_demux_sel <= r_route[w_pick];
        r_grant     <= 4'b0001 << w_pick;
      end else if (r_state == S_ACTIVE && w_state_nxt == S_ACTIVE) begin
        r_cnt <= r_cnt - 4'd1;
      end
      // Selects are deliberately held through RELEASE; only the grant drops.
      if (w_state_nxt == S_RELEASE) begin
        r_grant <= 4'd0;
      end
      r_en   <= (w_state_nxt == S_ACTIVE);
      r_busy <= (w_state_nxt != S_IDLE);
    end
  end

  assign o_mux_sel   = r_mux_sel;
  assign o_demux_sel = r_demux_sel;
  assign o_en        = r_en;
  assign o_grant     = r_grant;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_nibble_route_scheduler.sv
module tb_nibble_route_scheduler;

  localparam int SLOT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       route_we;
  logic [1:0] route_src;
  logic [1:0] route_dst;
  logic [1:0] mux_sel;
  logic [1:0] demux_sel;
  logic       en;
  logic [3:0] grant;
  logic       busy;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: slot position (-1 idle, 0 setup, 1..SLOT active cycle
  // number, SLOT+1 release), owner index, last winner, route table.
  int m_pos;
  int m_g;
  int m_last;
  int m_msel;
  int m_dsel;
  int m_route [4];

  always #5 clk = ~clk;

  nibble_route_scheduler #(.SLOT_CYCLES(SLOT)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req       (req),
    .i_route_we  (route_we),
    .i_route_src (route_src),
    .i_route_dst (route_dst),
    .o_mux_sel   (mux_sel),
    .o_demux_sel (demux_sel),
    .o_en        (en),
    .o_grant     (grant),
    .o_busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_edge(input logic [3:0] r, input logic we, input int src,
                            input int dst, input logic rs);
    int p;
    if (rs) begin
      m_pos = -1; m_last = 3; m_g = 0; m_msel = 0; m_dsel = 0;
      for (int i = 0; i < 4; i++) m_route[i] = i;
    end else begin
      p = pick(r, m_last);
      if (m_pos == -1 || m_pos == SLOT + 1) begin
        if (p >= 0) begin
          m_g = p; m_last = p; m_msel = p; m_dsel = m_route[p]; m_pos = 0;
        end else begin
          m_pos = -1;
        end
      end else if (m_pos == 0) begin
        m_pos = 1;
      end else if (m_pos == SLOT || !r[m_g]) begin
        m_pos = SLOT + 1;
      end else begin
        m_pos++;
      end
      if (we) m_route[src] = dst;
    end
  endtask

  // One clock: apply inputs, advance the model at the edge, compare #1 later.
  task automatic cyc(input logic [3:0] r, input logic we = 1'b0, input logic [1:0] src = 2'd0,
                     input logic [1:0] dst = 2'd0, input logic rs = 1'b0);
    logic [3:0] exp_grant;
    req = r; route_we = we; route_src = src; route_dst = dst; rst = rs;
    @(posedge clk);
    model_edge(r, we, int'(src), int'(dst), rs);
    #1;
    exp_grant = (m_pos >= 0 && m_pos <= SLOT) ? (4'b0001 << m_g) : 4'b0000;
    chk("grant", 32'(grant), 32'(exp_grant));
    chk("en", 32'(en), 32'(m_pos >= 1 && m_pos <= SLOT));
    chk("busy", 32'(busy), 32'(m_pos != -1));
    chk("mux_sel", 32'(mux_sel), 32'(m_msel));
    chk("demux_sel", 32'(demux_sel), 32'(m_dsel));
  endtask

  initial begin
    logic [15:0] sw;
    logic [15:0] led;
    logic [3:0]  rr;
    sw = 16'h6A59;
    rst = 1'b1; req = 4'd0; route_we = 1'b0; route_src = 2'd0; route_dst = 2'd0;

    // Reset state
    cyc(4'd0, 1'b0, 2'd0, 2'd0, 1'b1);
    cyc(4'd0, 1'b0, 2'd0, 2'd0, 1'b1);
    chk("rst_outputs", {25'd0, mux_sel, demux_sel, en, grant} , 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Single requester held: regrant every SLOT+2 cycles
    for (int c = 0; c < 3 * (SLOT + 2); c++) begin
      cyc(4'b0001);
      chk("solo_grant", 32'(grant), ((c % (SLOT + 2)) <= SLOT) ? 32'd1 : 32'd0);
      chk("solo_en", 32'(en), 32'((c % (SLOT + 2)) >= 1 && (c % (SLOT + 2)) <= SLOT));
    end

    // All requesting: strict rotation 0,1,2,3,0 with no idle gap
    cyc(4'd0, 1'b0, 2'd0, 2'd0, 1'b1);
    for (int c = 0; c < 5 * (SLOT + 2); c++) begin
      cyc(4'b1111);
      chk("rr_grant", 32'(grant),
          ((c % (SLOT + 2)) <= SLOT) ? (32'd1 << ((c / (SLOT + 2)) % 4)) : 32'd0);
      chk("rr_en", 32'(en), 32'((c % (SLOT + 2)) >= 1 && (c % (SLOT + 2)) <= SLOT));
      chk("rr_busy", 32'(busy), 32'd1);
    end

    // Route remap, led datapath, mid-slot rewrite only affects next grant
    cyc(4'd0, 1'b0, 2'd0, 2'd0, 1'b1);
    cyc(4'd0, 1'b1, 2'd1, 2'd3);
    cyc(4'b0010);
    chk("remap_mux", 32'(mux_sel), 32'd1);
    chk("remap_demux", 32'(demux_sel), 32'd3);
    cyc(4'b0010);
    led = 16'd0;
    if (en) led[demux_sel * 4 +: 4] = sw[mux_sel * 4 +: 4];
    chk("led_nibble3", 32'(led[15:12]), 32'd5);
    cyc(4'b0010, 1'b1, 2'd1, 2'd0);
    chk("demux_held", 32'(demux_sel), 32'd3);
    cyc(4'b0010);
    cyc(4'b0010);
    chk("demux_held_end", 32'(demux_sel), 32'd3);
    cyc(4'b0010);
    chk("release_en", 32'(en), 32'd0);
    cyc(4'b0010);
    chk("regrant_demux", 32'(demux_sel), 32'd0);

    // Early drop on the 2nd ACTIVE cycle
    cyc(4'd0, 1'b0, 2'd0, 2'd0, 1'b1);
    cyc(4'b0001);
    cyc(4'b0001);
    chk("drop_en1", 32'(en), 32'd1);
    cyc(4'b0001);
    chk("drop_en2", 32'(en), 32'd1);
    cyc(4'b0000);
    chk("drop_release", {30'd0, en, busy}, 32'b01);
    cyc(4'b0000);
    chk("drop_idle_busy", 32'(busy), 32'd0);

    // Reset mid-ACTIVE restores identity routing
    cyc(4'd0, 1'b1, 2'd2, 2'd1);
    cyc(4'b0100);
    chk("pre_rst_demux", 32'(demux_sel), 32'd1);
    cyc(4'b0100);
    cyc(4'b0100, 1'b0, 2'd0, 2'd0, 1'b1);
    chk("midrst_zero", {25'd0, mux_sel, demux_sel, en, grant, busy}, 32'd0);
    cyc(4'b0100);
    chk("post_rst_grant", 32'(grant), 32'b0100);
    chk("post_rst_demux", 32'(demux_sel), 32'd2);

    // Random traffic against the model
    rr = 4'd0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 3) == 0) rr = 4'($urandom_range(0, 15));
      cyc(rr, ($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)),
          2'($urandom_range(0, 3)), ($urandom_range(0, 299) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
